// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer between execute and the data-memory port.
// Optional bus wait limit is compiled in when MEM_TIMEOUT_EN is defined.

module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  read_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        resp_valid_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        timeout_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_t;

  function automatic size_t op_size(input logic [3:0] op);
    case (op)
      4'b1000, 4'b1100, 4'b1011: op_size = SZ_BYTE;
      4'b1001, 4'b1101, 4'b1110: op_size = SZ_HALF;
      4'b1010, 4'b1111:          op_size = SZ_WORD;
      default:                   op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == 4'b1011) || (op == 4'b1110) || (op == 4'b1111);
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_HALF: is_misaligned = a[0];
      SZ_WORD: is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: lane_strobe = 4'b0001 << a;
      SZ_HALF: lane_strobe = 4'b0011 << a;
      SZ_WORD: lane_strobe = 4'b1111;
      default: lane_strobe = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: lane_wdata = {4{d[7:0]}};
      SZ_HALF: lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Lane select followed by sign/zero extension chosen by the op code.
  function automatic logic [31:0] extend_load(input logic [3:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    b_s = rdata[{a, 3'b000} +: 8];
    h_s = rdata[{a[1], 4'b0000} +: 16];
    case (op)
      4'b1000: ext = 32'(b_s);
      4'b1001: ext = 32'(h_s);
      4'b1100: ext = {24'h000000, b_s};
      4'b1101: ext = {16'h0000, h_s};
      4'b1010: ext = rdata;
      default: ext = '0;
    endcase
    extend_load = ext;
  endfunction

  state_t state_q, state_d;

  logic        handshake;
  size_t       req_size;
  logic        req_mis;
  logic        req_store;
  logic        req_bus;

  logic [3:0]  op_p0;
  logic [31:0] addr_p0;
  logic        we_p0;
  logic [3:0]  wstrb_p0;
  logic [31:0] wdata_p0;
  logic        mis_p0;
  logic [31:0] load_p1;
  logic        tmo_p1;
  logic        tmo_hit;

  assign req_ready_o = (state_q == IDLE);
  assign handshake   = req_valid_i & req_ready_o;
  assign req_size    = op_size(read_write_i);
  assign req_mis     = is_misaligned(req_size, addr_i[1:0]);
  assign req_store   = op_is_store(read_write_i);
  assign req_bus     = (req_size != SZ_NONE) && !req_mis;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt_q;

  // Counter is zero on every ISSUE entry because it is held clear outside ISSUE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (state_q != ISSUE) begin
      wait_cnt_q <= '0;
    end else if (!mem_ack_i) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign tmo_hit = (state_q == ISSUE) && !mem_ack_i && (wait_cnt_q == TIMEOUT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = req_bus ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (mem_ack_i || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture stage: operation latched at the handshake edge.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      op_p0    <= read_write_i;
      addr_p0  <= addr_i;
      we_p0    <= req_store;
      wstrb_p0 <= req_store ? lane_strobe(req_size, addr_i[1:0]) : 4'b0000;
      wdata_p0 <= req_store ? lane_wdata(req_size, store_data_i) : '0;
      mis_p0   <= req_mis;
    end
  end

  // Response stage: load result and timeout flag, cleared for every new operation.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      load_p1 <= '0;
      tmo_p1  <= 1'b0;
    end else if (state_q == ISSUE) begin
      if (mem_ack_i) begin
        load_p1 <= we_p0 ? '0 : extend_load(op_p0, addr_p0[1:0], mem_rdata_i);
      end else if (tmo_hit) begin
        tmo_p1 <= 1'b1;
      end
    end
  end

  assign stall_o      = (state_q != IDLE);
  assign mem_req_o    = (state_q == ISSUE);
  assign mem_we_o     = mem_req_o & we_p0;
  assign mem_addr_o   = mem_req_o ? {addr_p0[31:2], 2'b00} : '0;
  assign mem_wstrb_o  = mem_req_o ? wstrb_p0 : 4'b0000;
  assign mem_wdata_o  = mem_req_o ? wdata_p0 : '0;

  assign resp_valid_o = (state_q == RESP);
  assign load_data_o  = resp_valid_o ? load_p1 : '0;
  assign misaligned_o = resp_valid_o & mis_p0;
`ifdef MEM_TIMEOUT_EN
  assign timeout_o    = resp_valid_o & tmo_p1;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule
